// File: rtl/alu_sequencer.sv
// Multi-cycle sequencer: fetch, decode, operand read, ALU exec, store.
// Ports: Clk/Rst_n, Run, Imem*/Dmem* handshakes, Alu* drive/capture, Acc/Pc/StatusFlags/Busy/Retired.
module alu_sequencer #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        Run,
  output logic        ImemReq,
  output logic [7:0]  ImemAddr,
  input  logic        ImemAck,
  input  logic [11:0] ImemData,
  output logic        DmemRd,
  output logic        DmemWr,
  output logic [7:0]  DmemAddr,
  output logic [7:0]  DmemWdata,
  input  logic        DmemAck,
  input  logic [7:0]  DmemRdata,
  output logic        AluEnable,
  output logic [3:0]  AluMode,
  output logic [7:0]  AluOperand1,
  output logic [7:0]  AluOperand2,
  output logic [3:0]  AluCflags,
  input  logic [7:0]  AluResult,
  input  logic [3:0]  AluFlags,
  output logic [7:0]  Acc,
  output logic [3:0]  StatusFlags,
  output logic [7:0]  Pc,
  output logic        Busy,
  output logic        Retired
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE,
    S_MEMRD, S_EXEC, S_MEMWR
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic [11:0] instr_q, instr_d;
  logic [7:0]  acc_q, acc_d;
  logic [7:0]  memop_q, memop_d;
  logic [7:0]  wb_q, wb_d;
  logic [3:0]  flags_q, flags_d;

  logic [3:0]  mode;
  logic        is_acc;
  logic        is_store;
  logic        flag_upd;

  assign mode = instr_q[11:8];

  always_comb begin
    is_acc   = 1'b0;
    is_store = 1'b0;
    flag_upd = 1'b0;
    unique case (mode)
      4'h2:             is_store = 1'b1;
      4'h8, 4'h9, 4'hF: begin
        is_acc   = 1'b1;
        flag_upd = 1'b1;
      end
      4'h0, 4'h1, 4'h4,
      4'h5, 4'h6, 4'h7: flag_upd = 1'b1;
      default:          ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    acc_d     = acc_q;
    memop_d   = memop_q;
    wb_d      = wb_q;
    flags_d   = flags_q;
    ImemReq   = 1'b0;
    DmemRd    = 1'b0;
    DmemWr    = 1'b0;
    AluEnable = 1'b0;
    Retired   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (Run) state_d = S_FETCH;
      end
      S_FETCH: begin
        ImemReq = 1'b1;
        if (ImemAck) begin
          instr_d = ImemData;
          pc_d    = pc_q + 8'd1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (is_acc || is_store) state_d = S_EXEC;
        else                    state_d = S_MEMRD;
      end
      S_MEMRD: begin
        DmemRd = 1'b1;
        if (DmemAck) begin
          memop_d = DmemRdata;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        AluEnable = 1'b1;
        if (flag_upd) flags_d = AluFlags;
        if (is_store) begin
          wb_d    = AluResult;
          state_d = S_MEMWR;
        end else begin
          acc_d   = AluResult;
          Retired = 1'b1;
          state_d = Run ? S_FETCH : S_IDLE;
        end
      end
      S_MEMWR: begin
        DmemWr = 1'b1;
        if (DmemAck) begin
          Retired = 1'b1;
          state_d = Run ? S_FETCH : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      acc_q   <= '0;
      memop_q <= '0;
      wb_q    <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      acc_q   <= acc_d;
      memop_q <= memop_d;
      wb_q    <= wb_d;
      flags_q <= flags_d;
    end
  end

  assign ImemAddr    = pc_q;
  assign DmemAddr    = instr_q[7:0];
  assign DmemWdata   = wb_q;
  assign AluMode     = mode;
  assign AluOperand1 = acc_q;
  assign AluOperand2 = memop_q;
  assign AluCflags   = flags_q;
  assign Acc         = acc_q;
  assign StatusFlags = flags_q;
  assign Pc          = pc_q;
  assign Busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: memory responders, ALU model,
// expectation queue popped by a Retired monitor.
module tb_alu_sequencer;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        Run = 1'b0;
  logic        ImemReq;
  logic [7:0]  ImemAddr;
  logic        ImemAck = 1'b0;
  logic [11:0] ImemData = '0;
  logic        DmemRd, DmemWr;
  logic [7:0]  DmemAddr, DmemWdata;
  logic        DmemAck;
  logic [7:0]  DmemRdata = '0;
  logic        AluEnable;
  logic [3:0]  AluMode;
  logic [7:0]  AluOperand1, AluOperand2;
  logic [3:0]  AluCflags;
  logic [7:0]  AluResult;
  logic [3:0]  AluFlags;
  logic [7:0]  Acc, Pc;
  logic [3:0]  StatusFlags;
  logic        Busy, Retired;

  alu_sequencer #(.RESET_PC(8'h00)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Run(Run),
    .ImemReq(ImemReq), .ImemAddr(ImemAddr),
    .ImemAck(ImemAck), .ImemData(ImemData),
    .DmemRd(DmemRd), .DmemWr(DmemWr),
    .DmemAddr(DmemAddr), .DmemWdata(DmemWdata),
    .DmemAck(DmemAck), .DmemRdata(DmemRdata),
    .AluEnable(AluEnable), .AluMode(AluMode),
    .AluOperand1(AluOperand1), .AluOperand2(AluOperand2),
    .AluCflags(AluCflags), .AluResult(AluResult),
    .AluFlags(AluFlags), .Acc(Acc),
    .StatusFlags(StatusFlags), .Pc(Pc),
    .Busy(Busy), .Retired(Retired)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  // ALU model, flags {Z,C,S,O}
  always_comb begin
    logic c, o;
    logic [8:0] s;
    c = 1'b0;
    o = 1'b0;
    s = '0;
    AluResult = AluOperand1;
    case (AluMode)
      4'h0: begin
        s = {1'b0, AluOperand1} + {1'b0, AluOperand2};
        AluResult = s[7:0];
        c = s[8];
        o = (AluOperand1[7] == AluOperand2[7]) &&
            (s[7] != AluOperand1[7]);
      end
      4'h1: begin
        AluResult = AluOperand1 - AluOperand2;
        c = AluOperand1 < AluOperand2;
        o = (AluOperand1[7] != AluOperand2[7]) &&
            (AluResult[7] != AluOperand1[7]);
      end
      4'h3: AluResult = AluOperand2;
      4'h8: begin
        s = {1'b0, AluOperand1} + 9'd1;
        AluResult = s[7:0];
        c = s[8];
        o = (AluOperand1 == 8'h7F);
      end
      4'hC: begin
        AluResult = {AluOperand1[6:0], 1'b0};
        c = AluOperand1[7];
      end
      default: AluResult = AluOperand1;
    endcase
    AluFlags = {AluResult == 8'h00, c, AluResult[7], o};
  end

  // memories and responders
  logic [11:0] imem [256];
  logic [7:0]  dmem [256];
  int  icnt = 0, dcnt = 0;
  logic dack_r = 1'b0;
  logic dack_force = 1'b0;
  logic dhold = 1'b0;
  assign DmemAck = dack_r | dack_force;

  function automatic int dwait(input logic [7:0] a);
    return (a == 8'h15) ? 3 : 0;
  endfunction

  always @(posedge Clk) begin
    #1;
    if (ImemReq) begin
      ImemAck  = (icnt == 0);
      ImemData = imem[ImemAddr];
      icnt     = icnt + 1;
    end else begin
      ImemAck = 1'b0;
      icnt    = 0;
    end
    if ((DmemRd || DmemWr) && !dhold) begin
      dack_r    = (dcnt == dwait(DmemAddr));
      DmemRdata = dmem[DmemAddr];
      dcnt      = dcnt + 1;
    end else begin
      dack_r = 1'b0;
      dcnt   = 0;
    end
  end

  // scoreboard
  typedef struct {
    logic [7:0] acc;
    logic [3:0] flg;
    logic [7:0] pc;
    logic       st;
    logic [7:0] wa;
    logic [7:0] wd;
    int         lat;
    int         rdc;
  } exp_t;

  exp_t q[$];
  exp_t pe;
  logic pend = 1'b0;

  task automatic push(input logic [7:0] acc,
                      input logic [3:0] flg,
                      input logic [7:0] pc,
                      input logic st,
                      input logic [7:0] wa,
                      input logic [7:0] wd,
                      input int lat,
                      input int rdc);
    exp_t e;
    e.acc = acc; e.flg = flg; e.pc = pc;
    e.st = st; e.wa = wa; e.wd = wd;
    e.lat = lat; e.rdc = rdc;
    q.push_back(e);
  endtask

  int cyc = 0, fstart = 0, rdn = 0, enn = 0;
  logic prev_req = 1'b0;
  logic saw_wr = 1'b0;
  logic [7:0] wa_s = '0, wd_s = '0;

  always @(negedge Clk) begin
    exp_t e;
    cyc++;
    if (pend) begin
      chk("acc", Acc, pe.acc);
      chk("flags", StatusFlags, pe.flg);
      chk("pc", Pc, pe.pc);
      pend = 1'b0;
    end
    if (ImemReq && !prev_req) begin
      fstart = cyc;
      rdn = 0;
      enn = 0;
      saw_wr = 1'b0;
    end
    prev_req = ImemReq;
    if (DmemRd) rdn++;
    if (AluEnable) enn++;
    if (DmemWr && DmemAck) begin
      saw_wr = 1'b1;
      wa_s = DmemAddr;
      wd_s = DmemWdata;
    end
    if (Retired) begin
      if (q.size() == 0) begin
        chk("unexpected_retire", 1, 0);
      end else begin
        e = q.pop_front();
        chk("latency", cyc - fstart + 1, e.lat);
        chk("rd_cycles", rdn, e.rdc);
        chk("exec_cycles", enn, 1);
        chk("store_seen", {31'b0, saw_wr}, {31'b0, e.st});
        if (e.st) begin
          chk("wr_addr", wa_s, e.wa);
          chk("wr_data", wd_s, e.wd);
        end
        pe = e;
        pend = 1'b1;
      end
    end
  end

  task automatic wait_drain(input int maxc);
    int n;
    n = 0;
    while ((q.size() != 0 || pend || Busy) && n < maxc) begin
      @(negedge Clk);
      n++;
    end
    chk("drain_timeout", {31'b0, n >= maxc}, 0);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 256; i++) begin
      imem[i] = 12'h316;
      dmem[i] = 8'h00;
    end
    imem[0] = 12'h311; imem[1] = 12'h010;
    imem[2] = 12'h312; imem[3] = 12'h112;
    imem[4] = 12'h313; imem[5] = 12'hC10;
    imem[6] = 12'h314; imem[7] = 12'h220;
    imem[8] = 12'h800; imem[9] = 12'h015;
    imem[255] = 12'h800;
    dmem[8'h10] = 8'h03; dmem[8'h11] = 8'h05;
    dmem[8'h12] = 8'h07; dmem[8'h13] = 8'h81;
    dmem[8'h14] = 8'h5A; dmem[8'h15] = 8'hA5;
    dmem[8'h16] = 8'h33;

    repeat (3) @(negedge Clk);
    chk("rst_busy", {31'b0, Busy}, 0);
    chk("rst_pc", Pc, 8'h00);
    chk("rst_acc", Acc, 8'h00);
    chk("rst_flags", StatusFlags, 4'h0);
    chk("rst_ireq", {31'b0, ImemReq}, 0);
    Rst_n = 1'b1;
    @(negedge Clk);

    push(8'h05, 4'h0, 8'h01, 0, 0, 0, 4, 1);
    push(8'h08, 4'h0, 8'h02, 0, 0, 0, 4, 1);
    push(8'h07, 4'h0, 8'h03, 0, 0, 0, 4, 1);
    push(8'h00, 4'h8, 8'h04, 0, 0, 0, 4, 1);
    push(8'h81, 4'h8, 8'h05, 0, 0, 0, 4, 1);
    push(8'h02, 4'h8, 8'h06, 0, 0, 0, 4, 1);
    push(8'h5A, 4'h8, 8'h07, 0, 0, 0, 4, 1);
    push(8'h5A, 4'h8, 8'h08, 1, 8'h20, 8'h5A, 4, 0);
    push(8'h5B, 4'h0, 8'h09, 0, 0, 0, 3, 0);
    push(8'h00, 4'hC, 8'h0A, 0, 0, 0, 7, 4);
    for (int a = 10; a < 255; a++)
      push(8'h33, 4'hC, 8'(a + 1), 0, 0, 0, 4, 1);
    push(8'h34, 4'h0, 8'h00, 0, 0, 0, 3, 0);

    Run = 1'b1;
    n = 0;
    while (!(ImemReq && ImemAck && ImemAddr == 8'hFF) &&
           n < 3000) begin
      @(negedge Clk);
      n++;
    end
    chk("reach_ff_timeout", {31'b0, n >= 3000}, 0);
    @(negedge Clk);
    Run = 1'b0;
    wait_drain(40);
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      chk("idle_busy", {31'b0, Busy}, 0);
      chk("idle_ireq", {31'b0, ImemReq}, 0);
    end
    chk("wrap_pc", Pc, 8'h00);

    dhold = 1'b1;
    Run = 1'b1;
    n = 0;
    while (!DmemRd && n < 20) begin
      @(negedge Clk);
      n++;
    end
    chk("memrd_timeout", {31'b0, n >= 20}, 0);
    Run = 1'b0;
    @(negedge Clk);
    Rst_n = 1'b0;
    #1;
    chk("arst_dmemrd", {31'b0, DmemRd}, 0);
    chk("arst_busy", {31'b0, Busy}, 0);
    chk("arst_pc", Pc, 8'h00);
    chk("arst_acc", Acc, 8'h00);
    @(negedge Clk);
    Rst_n = 1'b1;
    dhold = 1'b0;
    dack_force = 1'b1;
    repeat (2) @(negedge Clk);
    chk("late_ack_busy", {31'b0, Busy}, 0);
    chk("late_ack_acc", Acc, 8'h00);
    chk("late_ack_pc", Pc, 8'h00);
    dack_force = 1'b0;

    push(8'h05, 4'h0, 8'h01, 0, 0, 0, 4, 1);
    Run = 1'b1;
    @(negedge Clk);
    chk("restart_ireq", {31'b0, ImemReq}, 1);
    chk("restart_addr", ImemAddr, 8'h00);
    @(negedge Clk);
    Run = 1'b0;
    wait_drain(20);
    chk("queue_empty", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle control unit that fetches 12-bit instructions, sequences the 8-bit ALU through each one, and owns the accumulator, program counter and status-flag register. It sits between program memory, data memory and the combinational ALU. It drives the ALU's Enable/Mode/operand/flag inputs and captures its Result and Flags. Instruction format: Instr[11:8] = ALU Mode, Instr[7:0] = data-memory address.

## Interface
- RESET_PC, 8'h00, Pc value loaded on reset.
- Clk  in  1  rising-edge clock for all state.
- Rst_n  in  1  asynchronous, active-low reset.
- Run  in  1  level; high lets the sequencer start and continue instructions.
- ImemReq  out  1  instruction fetch request; held until ImemAck.
- ImemAddr  out  8  fetch address; equals Pc.
- ImemAck  in  1  fetch complete; ImemData is valid in the same cycle.
- ImemData  in  12  instruction word.
- DmemRd  out  1  data read request; held until DmemAck.
- DmemWr  out  1  data write request; held until DmemAck.
- DmemAddr  out  8  data address; equals Instr[7:0].
- DmemWdata  out  8  write data; equals the latched ALU result.
- DmemAck  in  1  data transfer complete; DmemRdata is valid in the same cycle for reads.
- DmemRdata  in  8  read data.
- AluEnable  out  1  high only in EXEC.
- AluMode  out  4  equals Instr[11:8].
- AluOperand1  out  8  equals Acc.
- AluOperand2  out  8  equals the latched memory operand (MemOp).
- AluCflags  out  4  equals StatusFlags.
- AluResult  in  8  ALU result.
- AluFlags  in  4  ALU flags, ordered {Z, C, S, O}.
- Acc  out  8  accumulator.
- StatusFlags  out  4  flag register, ordered {Z, C, S, O}.
- Pc  out  8  program counter.
- Busy  out  1  high when the state is not IDLE.
- Retired  out  1  one-cycle pulse when an instruction completes.

## Operation
- States: IDLE, FETCH, DECODE, MEMRD, EXEC, MEMWR.
- IDLE
  - Goes to FETCH when Run=1.
- FETCH
  - ImemReq=1.
  - On ImemAck: latch ImemData into Instr, Pc <= Pc+1 (mod 256), go to DECODE.
- DECODE
  - One cycle. Classify the instruction by mode:
    - Read class, modes 0000, 0001, 0011-0111, 1010-1110: go to MEMRD.
    - Accumulator-only class, modes 1000, 1001, 1111: go to EXEC; MemOp is not updated.
    - Store class, mode 0010: go to EXEC.
- MEMRD
  - DmemRd=1.
  - On DmemAck: MemOp <= DmemRdata, go to EXEC.
- EXEC
  - AluEnable=1 for one cycle; the ALU is combinational.
  - Store class: latch AluResult into WbData, go to MEMWR.
  - All other classes: Acc <= AluResult and Retired=1.
- MEMWR
  - DmemWr=1, DmemWdata=WbData.
  - On DmemAck: Retired=1.
- End of instruction, on leaving EXEC (non-store) or MEMWR:
  - Go to FETCH if Run=1, otherwise IDLE.
- Flag update: StatusFlags <= AluFlags at the end of EXEC only for modes 0000, 0001, 0100-1001 and 1111. All other modes leave StatusFlags unchanged.
- Width rules: all data is 8 bits, with no sign extension anywhere. Pc wraps 8'hFF -> 8'h00.
- Acks:
  - ImemAck is ignored outside FETCH.
  - DmemAck is ignored outside MEMRD and MEMWR.
  - A request is never dropped before its ack.
- Run deasserted mid-instruction: the current instruction completes, then the sequencer goes to IDLE. Pc then points at the next instruction.
- Reset (asynchronous, at any time, including mid-transfer):
  - State=IDLE, Pc=RESET_PC.
  - Acc, MemOp, WbData and StatusFlags are 0; Instr is 0.
  - All request, enable, Busy and Retired outputs go to 0 immediately.
  - A pending ack arriving after reset is ignored.

## Timing
- Requests and AluEnable are registered-state decodes. They assert in the first cycle of their state.
- Zero-wait memory (ack in the first request cycle):
  - Read class: 4 cycles from FETCH entry to Retired (FETCH, DECODE, MEMRD, EXEC).
  - Accumulator-only class: 3 cycles.
  - Store class: 4 cycles; Retired asserts in the MEMWR ack cycle.
- Each wait cycle on an ack adds exactly one cycle to that state.
- Acc, StatusFlags and Pc update on the clock edge that ends the relevant state. The new values are visible the next cycle.
- With Run held high, back-to-back instructions have no bubble: FETCH of instruction n+1 starts the cycle after Retired of instruction n.
- From IDLE, Run=1 sampled at edge k puts the sequencer in FETCH in cycle k+1.

## Test plan
- Add: Acc=8'h05, mem[8'h10]=8'h03, instruction 12'h010, zero-wait -> Acc=8'h08 after 4 cycles, Retired pulses once, Pc incremented by 1.
- Store: Acc=8'h5A, instruction 12'h2_20 -> DmemWr with DmemAddr=8'h20 and DmemWdata=8'h5A, Acc and StatusFlags unchanged.
- Flag retention:
  - Sub equal values (Acc=8'h07, mem=8'h07, mode 0001) -> StatusFlags=AluFlags captured.
  - A following mode 1100 shift -> StatusFlags unchanged.
- Wait states: DmemAck delayed 3 cycles -> DmemRd held for 4 cycles, total latency 7, no early EXEC.
- Run and wrap: Pc=8'hFF with Run dropped during DECODE -> instruction retires, state IDLE, Pc=8'h00, no further ImemReq.
- Reset mid-MEMRD: Rst_n pulsed low -> DmemRd drops immediately, Pc=RESET_PC, a late DmemAck is ignored, restart fetches from RESET_PC.
